io_ram_arbiter: RTL and testbench
=================================

// Module: io_ram_arbiter
// PURPOSE
//  Shares the single IO slot of the SDRAM host interface between two requesters:
//  A = SPI data client (rom/floppy/harddisk upload), B = DMA engine.
//  Transfers start only in the IO bus slot; round-robin on contention.
//  Drives the read/write strobes, address and write data of the sdram host port;
//  returns read data and a one-cycle ack per requester.
// PARAMETERS
//  SLOT     2'd3  bus_cycle value in which a transfer may be granted
//  LATENCY  2     posedges from strobe-asserting edge to data_in capture (1..7)
// PORTS
//  clk_8      in   1   8MHz system clock; all logic on posedge
//  reset      in   1   synchronous, active-high reset
//  bus_cycle  in   2   current bus slot (0..3), stable at posedge
//  a_req      in   1   A request, level; held until a_ack
//  a_we       in   1   A: 1=write, 0=read; valid while a_req
//  a_addr     in   23  A word address
//  a_wdata    in   16  A write data
//  a_ack      out  1   A transfer complete, one cycle
//  a_rdata    out  16  A read data, valid from a_ack, held until next A read
//  b_req/b_we/b_addr/b_wdata/b_ack/b_rdata   as A, for requester B
//  read       out  1   sdram read strobe, one cycle per transfer
//  write      out  1   sdram write strobe, one cycle per transfer
//  addr       out  23  sdram word address
//  data_out   out  16  sdram write data
//  data_in    in   16  sdram read data
//  busy       out  1   high in WAIT and DONE
//  grant_b    out  1   owner of current/last transfer (0=A, 1=B)
// BEHAVIOUR
//  Reset: state IDLE; read, write, a_ack, b_ack, busy = 0; addr, data_out,
//   a_rdata, b_rdata = 0; cnt = 0; grant_b = 1 (so A wins the first contention).
//  States: IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: at edge E0 with bus_cycle==SLOT and (a_req|b_req):
//   - winner: only requester if one; if both, the one != grant_b
//   - grant_b <= winner; addr <= winner addr; data_out <= winner wdata
//   - write <= winner we; read <= ~winner we; cnt <= 0; state <= WAIT
//   - requests with bus_cycle!=SLOT wait; no strobe.
//  WAIT: read/write forced 0 at first WAIT edge (strobe exactly 1 cycle).
//   At each edge: if cnt==LATENCY-1: if read transfer, winner rdata <= data_in;
//   winner ack <= 1; state <= DONE; else cnt <= cnt+1.
//   data_in therefore sampled LATENCY posedges after E0.
//  DONE: one cycle, ack high; next edge ack <= 0, state <= IDLE.
//   Requester drops req in the DONE cycle; if req still high in IDLE it is a new
//   transfer, granted at the next SLOT (round robin still applies).
//  addr/data_out hold from E0 until the next grant (stable through capture).
//  Write transfers leave both rdata registers unchanged.
//  Request changes during WAIT/DONE are ignored; the other requester waits.
//  Reset in any state: immediate return to reset values; no ack for aborted
//   transfer; strobes drop in same edge.
//  cnt is 3 bits; LATENCY outside 1..7 is unsupported.
// TESTING
//  1 A read 0x012345, data_in=0xBEEF at capture edge, LATENCY=2 -> read high 1 cycle
//    at slot 3, addr=0x012345, a_ack 2 edges later, a_rdata=0xBEEF, b_ack stays 0.
//  2 B write addr 0x7FFFFF data 0x1234 raised at bus_cycle 0 -> no strobe until
//    bus_cycle==3; write 1 cycle, data_out=0x1234; b_ack; rdata unchanged.
//  3 A and B both req from reset, held -> order A,B,A,B on consecutive slots;
//    grant_b toggles 0,1,0,1.
//  4 reset asserted while in WAIT -> read/write/ack 0 next edge, no ack, state IDLE;
//    after release, pending A req granted at next slot.
//  5 A req held high through DONE -> second A transfer at next slot 3, exactly
//    one strobe and one ack per transfer.
//  6 LATENCY=1 read -> data_in captured and a_ack set at first edge after E0.

Source files
------------

// File: rtl/io_ram_arbiter.sv
// io_ram_arbiter: shares the SDRAM IO slot between the SPI client (A) and DMA (B).
// Grants only in SLOT, round-robin on contention, one ack per transfer.
module io_ram_arbiter #(
  parameter logic [1:0]  SLOT    = 2'd3,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_8,
  input  logic        reset,
  input  logic [1:0]  bus_cycle,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [22:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [22:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        read,
  output logic        write,
  output logic [22:0] addr,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        grant_b
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [2:0] CNT_LAST = 3'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        grant_b_q, grant_b_d;
  logic        we_q, we_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [15:0] a_rdata_q, a_rdata_d;
  logic [15:0] b_rdata_q, b_rdata_d;
  logic        win_b;

  // B wins if alone, or if both ask and A owned the last transfer
  assign win_b = b_req & (~a_req | ~grant_b_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_b_d = grant_b_q;
    we_d      = we_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    addr_d    = addr_q;
    dout_d    = dout_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus_cycle == SLOT && (a_req | b_req)) begin
          grant_b_d = win_b;
          we_d      = win_b ? b_we : a_we;
          addr_d    = win_b ? b_addr : a_addr;
          dout_d    = win_b ? b_wdata : a_wdata;
          write_d   = we_d;
          read_d    = ~we_d;
          cnt_d     = 3'd0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) begin
            if (grant_b_q) b_rdata_d = data_in;
            else           a_rdata_d = data_in;
          end
          b_ack_d = grant_b_q;
          a_ack_d = ~grant_b_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_8) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      grant_b_q <= 1'b1;
      we_q      <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 23'd0;
      dout_q    <= 16'd0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= 16'd0;
      b_rdata_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_b_q <= grant_b_d;
      we_q      <= we_d;
      read_q    <= read_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign read     = read_q;
  assign write    = write_q;
  assign addr     = addr_q;
  assign data_out = dout_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign grant_b  = grant_b_q;
  assign busy     = (state_q == S_WAIT) || (state_q == S_DONE);

endmodule

// File: tb/tb_io_ram_arbiter.sv
// tb_io_ram_arbiter: random two-requester traffic against a transaction model,
// run once with LATENCY=2 and once with LATENCY=1.
module tb_io_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic [1:0]  bc;
  logic        a_req, a_we, b_req, b_we;
  logic [22:0] a_addr, b_addr;
  logic [15:0] a_wd, b_wd, din;

  logic        r2, w2, aa2, ba2, bz2, g2;
  logic [22:0] ad2;
  logic [15:0] do2, ard2, brd2;
  logic        r1, w1, aa1, ba1, bz1, g1;
  logic [22:0] ad1;
  logic [15:0] do1, ard1, brd1;

  logic        o_rd, o_wr, o_aack, o_back, o_busy, o_gb;
  logic [22:0] o_addr;
  logic [15:0] o_dout, o_ard, o_brd;

  io_ram_arbiter #(.LATENCY(2)) u_dut2 (
    .clk_8(clk), .reset(rst), .bus_cycle(bc),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wd),
    .a_ack(aa2), .a_rdata(ard2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wd),
    .b_ack(ba2), .b_rdata(brd2),
    .read(r2), .write(w2), .addr(ad2), .data_out(do2),
    .data_in(din), .busy(bz2), .grant_b(g2)
  );

  io_ram_arbiter #(.LATENCY(1)) u_dut1 (
    .clk_8(clk), .reset(rst), .bus_cycle(bc),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wd),
    .a_ack(aa1), .a_rdata(ard1),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wd),
    .b_ack(ba1), .b_rdata(brd1),
    .read(r1), .write(w1), .addr(ad1), .data_out(do1),
    .data_in(din), .busy(bz1), .grant_b(g1)
  );

  always_comb begin
    o_rd   = sel ? r1   : r2;
    o_wr   = sel ? w1   : w2;
    o_aack = sel ? aa1  : aa2;
    o_back = sel ? ba1  : ba2;
    o_busy = sel ? bz1  : bz2;
    o_gb   = sel ? g1   : g2;
    o_addr = sel ? ad1  : ad2;
    o_dout = sel ? do1  : do2;
    o_ard  = sel ? ard1 : ard2;
    o_brd  = sel ? brd1 : brd2;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_val(input logic [22:0] a);
    return a[15:0] ^ {a[22:16], a[8:0]} ^ 16'h5A3C;
  endfunction

  function automatic logic [22:0] pick_addr();
    unique case ($urandom_range(3))
      0:       return 23'h000000;
      1:       return 23'h7FFFFF;
      default: return 23'($urandom);
    endcase
  endfunction

  // transaction-level model state
  int          cyc, s_cyc, idle_from, lat;
  int          a_idle, b_idle, a_wait, b_wait, max_wait;
  bit          m_out, m_last, m_we, w, grant, ack, wrst_done;
  logic [22:0] m_addr;
  logic [15:0] m_dout, m_ard, m_brd;

  initial begin
    rst = 1'b1; sel = 1'b0; bc = 2'd0; din = 16'd0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wd = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wd = '0;
    max_wait = 0; a_wait = 0; b_wait = 0;
    m_out = 0; m_last = 1; m_we = 0; w = 0; grant = 0; ack = 0;
    m_addr = '0; m_dout = '0; m_ard = '0; m_brd = '0;
    s_cyc = 0; idle_from = 0;
    for (int ph = 0; ph < 2; ph++) begin
      sel = (ph == 1);
      lat = (ph == 1) ? 1 : 2;
      rst = 1'b1;
      a_req = 1'b0; b_req = 1'b0;
      a_idle = 0; b_idle = 3; wrst_done = 0;
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        cyc = c;
        grant = 0; ack = 0;
        if (rst) begin
          check("rst_read", 32'(o_rd), 32'd0);
          check("rst_write", 32'(o_wr), 32'd0);
          check("rst_a_ack", 32'(o_aack), 32'd0);
          check("rst_b_ack", 32'(o_back), 32'd0);
          check("rst_busy", 32'(o_busy), 32'd0);
          check("rst_grant_b", 32'(o_gb), 32'd1);
          check("rst_addr", 32'(o_addr), 32'd0);
          check("rst_dout", 32'(o_dout), 32'd0);
          check("rst_a_rdata", 32'(o_ard), 32'd0);
          check("rst_b_rdata", 32'(o_brd), 32'd0);
          m_out = 0; m_last = 1; m_addr = '0; m_dout = '0;
          m_ard = '0; m_brd = '0; idle_from = 0;
        end else begin
          grant = !m_out && cyc >= idle_from && bc == 2'd3 &&
                  (a_req || b_req);
          if (grant) begin
            w      = (a_req && b_req) ? !m_last : b_req;
            m_last = w;
            m_we   = w ? b_we : a_we;
            m_addr = w ? b_addr : a_addr;
            m_dout = w ? b_wd : a_wd;
            m_out  = 1;
            s_cyc  = cyc;
          end
          ack = m_out && (cyc == s_cyc + lat);
          if (ack && !m_we) begin
            if (m_last) m_brd = mem_val(m_addr);
            else        m_ard = mem_val(m_addr);
          end
          check("read", 32'(o_rd), 32'(grant && !m_we));
          check("write", 32'(o_wr), 32'(grant && m_we));
          check("a_ack", 32'(o_aack), 32'(ack && !m_last));
          check("b_ack", 32'(o_back), 32'(ack && m_last));
          check("busy", 32'(o_busy), 32'(m_out));
          check("grant_b", 32'(o_gb), 32'(m_last));
          check("addr", 32'(o_addr), 32'(m_addr));
          check("data_out", 32'(o_dout), 32'(m_dout));
          check("a_rdata", 32'(o_ard), 32'(m_ard));
          check("b_rdata", 32'(o_brd), 32'(m_brd));
          if (ack) begin
            m_out = 0;
            idle_from = cyc + 2;
          end
        end
        // requester A
        if (ack && !m_last) begin
          a_wait = 0;
          if ($urandom_range(2) == 0) begin
            a_we = 1'($urandom_range(1)); a_addr = pick_addr();
            a_wd = 16'($urandom);
          end else begin
            a_req = 1'b0; a_idle = $urandom_range(6);
          end
        end else if (!a_req) begin
          if (a_idle == 0) begin
            a_req = 1'b1; a_we = 1'($urandom_range(1));
            a_addr = pick_addr(); a_wd = 16'($urandom);
          end else a_idle--;
        end else a_wait++;
        // requester B
        if (ack && m_last) begin
          b_wait = 0;
          if ($urandom_range(2) == 0) begin
            b_we = 1'($urandom_range(1)); b_addr = pick_addr();
            b_wd = 16'($urandom);
          end else begin
            b_req = 1'b0; b_idle = $urandom_range(6);
          end
        end else if (!b_req) begin
          if (b_idle == 0) begin
            b_req = 1'b1; b_we = 1'($urandom_range(1));
            b_addr = pick_addr(); b_wd = 16'($urandom);
          end else b_idle--;
        end else b_wait++;
        if (a_wait > max_wait) max_wait = a_wait;
        if (b_wait > max_wait) max_wait = b_wait;
        // reset: start of phase, occasional random, and once mid-transfer
        rst = (c < 2) || ($urandom_range(79) == 0);
        if (!wrst_done && c > 100 && m_out && cyc == s_cyc) begin
          rst = 1'b1;
          wrst_done = 1;
        end
        din = (m_out && cyc == s_cyc + lat - 1) ? mem_val(m_addr)
                                                : 16'($urandom);
        bc = bc + 2'd1;
      end
      check("mid_wait_reset_hit", 32'(wrst_done), 32'd1);
    end
    check("max_req_wait_ok", 32'(max_wait <= 64), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
